pipeline_xy_packer: RTL and testbench

Downstream consumer of the two-output `pipeline` stage. It samples the X/Y result bit pair on each qualified cycle and packs consecutive pairs into words. Completed words are buffered in a small FIFO and handed out over a valid/ready interface. The block turns the pipeline's bit-level results into word transfers for the next stage and flags lost data.

---
 rtl/pipeline_xy_pkg.sv | 18 +
 rtl/xy_sync_fifo.sv | 48 ++++
 rtl/pipeline_xy_packer.sv | 113 +++++++++++
 tb/tb_pipeline_xy_packer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_xy_pkg.sv
// Shared constants and default FIFO entry layout for the X/Y packer.
// The parity field exists only when XY_PACK_PARITY_EN is defined.
package pipeline_xy_pkg;

  localparam int unsigned PAIRS_DEFAULT = 4;
  localparam int unsigned DEPTH_DEFAULT = 4;
  localparam int unsigned WORD_W_DEFAULT  = 2 * PAIRS_DEFAULT;
  localparam int unsigned COUNT_W_DEFAULT = $clog2(PAIRS_DEFAULT) + 1;

  typedef struct packed {
    logic [WORD_W_DEFAULT-1:0]  word;
    logic [COUNT_W_DEFAULT-1:0] count;
`ifdef XY_PACK_PARITY_EN
    logic                       parity;
`endif
  } xy_entry_t;

endpackage

// File: rtl/xy_sync_fifo.sv
// Single-clock FIFO with async-reset pointers and an occupancy count.
// Caller guarantees push only when not full (or popping) and pop only when non-empty.
module xy_sync_fifo
  import pipeline_xy_pkg::*;
#(
  parameter type         entry_t = xy_entry_t,
  parameter int unsigned DEPTH   = DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  entry_t                   wr_entry,
  output entry_t                   rd_entry,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  entry_t        mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  // At full with a simultaneous pop, wr_ptr == rd_ptr: the head is consumed
  // this edge, so overwriting its slot is safe.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  assign rd_entry = mem[rd_ptr];
  assign full     = (level == LW'(DEPTH));

endmodule

// File: rtl/pipeline_xy_packer.sv
// Packs qualified X/Y result pairs into words and buffers them for a valid/ready consumer.
// Optional out_parity port enabled by defining XY_PACK_PARITY_EN.
module pipeline_xy_packer
  import pipeline_xy_pkg::*;
#(
  parameter int unsigned PAIRS = PAIRS_DEFAULT,
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       X,
  input  logic                       Y,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*PAIRS-1:0]         out_data,
  output logic [$clog2(PAIRS):0]     out_count,
  output logic [$clog2(DEPTH):0]     level,
`ifdef XY_PACK_PARITY_EN
  output logic                       out_parity,
`endif
  output logic                       overflow
);

  localparam int unsigned W  = 2 * PAIRS;
  localparam int unsigned CW = $clog2(PAIRS) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(PAIRS);

  typedef struct packed {
    logic [W-1:0]  word;
    logic [CW-1:0] count;
`ifdef XY_PACK_PARITY_EN
    logic          parity;
`endif
  } entry_t;

  logic [W-1:0]  word_q;
  logic [W-1:0]  word_nxt;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_nxt;
  logic          push;
  logic          pop;
  logic          accept;
  logic          full;
  entry_t        wr_entry;
  entry_t        rd_entry;

  // The current pair is merged before the push decision so flush+in_valid
  // and the completing pair both land in the pushed word.
  always_comb begin
    word_nxt = word_q;
    cnt_nxt  = cnt_q;
    if (in_valid) begin
      for (int unsigned k = 0; k < PAIRS; k++) begin
        if (cnt_q == k[CW-1:0]) word_nxt[2*k +: 2] = {X, Y};
      end
      cnt_nxt = cnt_q + 1'b1;
    end
  end

  always_comb begin
    push     = (in_valid && (cnt_nxt == FULL_CNT)) || (flush && (cnt_nxt != '0));
    pop      = out_valid && out_ready;
    accept   = push && (!full || pop);
    wr_entry = '0;
    wr_entry.word  = word_nxt;
    wr_entry.count = cnt_nxt;
`ifdef XY_PACK_PARITY_EN
    wr_entry.parity = ^word_nxt;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (push) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_nxt;
      cnt_q  <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  overflow <= 1'b0;
    else if (push && !accept) overflow <= 1'b1;
  end

  xy_sync_fifo #(
    .entry_t (entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (accept),
    .pop      (pop),
    .wr_entry (wr_entry),
    .rd_entry (rd_entry),
    .level    (level),
    .full     (full)
  );

  assign out_valid = (level != '0);
  assign out_data  = out_valid ? rd_entry.word  : '0;
  assign out_count = out_valid ? rd_entry.count : '0;
`ifdef XY_PACK_PARITY_EN
  assign out_parity = out_valid ? rd_entry.parity : 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_xy_packer.sv
// Self-checking bench for pipeline_xy_packer: queue-based reference model plus directed pins.
// Parity checks are active when XY_PACK_PARITY_EN is defined.
module tb_pipeline_xy_packer;

  localparam int unsigned PAIRS = 4;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       X = 1'b0;
  logic       Y = 1'b0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic [2:0] out_count;
  logic [2:0] level;
  logic       overflow;
`ifdef XY_PACK_PARITY_EN
  logic       out_parity;
`endif

  always #5 clk = ~clk;

  pipeline_xy_packer #(
    .PAIRS (PAIRS),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .X         (X),
    .Y         (Y),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .level     (level),
`ifdef XY_PACK_PARITY_EN
    .out_parity(out_parity),
`endif
    .overflow  (overflow)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: queue of words; the pending word is built by placing pair c at bits [2c+1:2c].
  logic [7:0] mq_word[$];
  int         mq_cnt[$];
  logic [7:0] m_word = '0;
  int         m_cnt = 0;
  bit         m_ovf = 0;
  logic [7:0] m_w;
  int         m_c;
  bit         m_push;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq_word.delete();
      mq_cnt.delete();
      m_word = '0;
      m_cnt  = 0;
      m_ovf  = 0;
    end else begin
      m_w = m_word;
      m_c = m_cnt;
      if (in_valid) begin
        m_w[2*m_c +: 2] = {X, Y};
        m_c++;
      end
      m_push = (in_valid && m_c == PAIRS) || (flush && m_c != 0);
      if (mq_word.size() != 0 && out_ready) begin
        void'(mq_word.pop_front());
        void'(mq_cnt.pop_front());
      end
      if (m_push) begin
        if (mq_word.size() < DEPTH) begin
          mq_word.push_back(m_w);
          mq_cnt.push_back(m_c);
        end else begin
          m_ovf = 1;
        end
        m_word = '0;
        m_cnt  = 0;
      end else begin
        m_word = m_w;
        m_cnt  = m_c;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", 32'(out_valid), 32'(mq_word.size() != 0));
      chk("out_data",  32'(out_data),  (mq_word.size() != 0) ? 32'(mq_word[0]) : 32'd0);
      chk("out_count", 32'(out_count), (mq_word.size() != 0) ? 32'(mq_cnt[0])  : 32'd0);
      chk("level",     32'(level),     32'(mq_word.size()));
      chk("overflow",  32'(overflow),  32'(m_ovf));
`ifdef XY_PACK_PARITY_EN
      chk("out_parity", 32'(out_parity), (mq_word.size() != 0) ? 32'(^mq_word[0]) : 32'd0);
`endif
    end
  end

  task automatic cyc(input logic v, input logic x, input logic y, input logic f, input logic r);
    @(negedge clk);
    in_valid  = v;
    X         = x;
    Y         = y;
    flush     = f;
    out_ready = r;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] w, input logic r_last, input logic r);
    for (int k = 0; k < 4; k++)
      cyc(1'b1, w[2*k+1], w[2*k], 1'b0, (k == 3) ? r_last : r);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 0; flush = 0; out_ready = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_level", 32'(level),     32'd0);
    rst = 0;

    // 1: full word E7
    cyc(1, 1, 1, 0, 1);
    cyc(1, 0, 1, 0, 1);
    cyc(1, 1, 0, 0, 1);
    cyc(1, 1, 1, 0, 1);
    settle();
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_data",  32'(out_data),  32'hE7);
    chk("t1_count", 32'(out_count), 32'd4);
`ifdef XY_PACK_PARITY_EN
    chk("t1_parity", 32'(out_parity), 32'd0);
`endif
    cyc(0, 0, 0, 0, 1);

    // 2: partial word then flush; then empty flush
    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);
    settle();
    chk("t2_data",  32'(out_data),  32'h06);
    chk("t2_count", 32'(out_count), 32'd2);
    chk("t2_level", 32'(level),     32'd1);
    cyc(0, 0, 0, 1, 0);
    settle();
    chk("t2_empty_flush_level", 32'(level), 32'd1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);

    // 3: fill, overflow, drain in order
    push_word(8'hA1, 0, 0);
    push_word(8'hB2, 0, 0);
    push_word(8'hC3, 0, 0);
    push_word(8'hD4, 0, 0);
    settle();
    chk("t3_level_full", 32'(level),    32'd4);
    chk("t3_ovf_before", 32'(overflow), 32'd0);
    push_word(8'hE5, 0, 0);
    settle();
    chk("t3_ovf_after",  32'(overflow), 32'd1);
    chk("t3_level_hold", 32'(level),    32'd4);
    chk("t3_head",       32'(out_data), 32'hA1);
    repeat (4) cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    settle();
    chk("t3_drained", 32'(level), 32'd0);

    // 4: push and pop together at full
    do_reset();
    push_word(8'h11, 0, 0);
    push_word(8'h22, 0, 0);
    push_word(8'h33, 0, 0);
    push_word(8'h44, 0, 0);
    push_word(8'h55, 1, 0);
    settle();
    chk("t4_level", 32'(level),    32'd4);
    chk("t4_ovf",   32'(overflow), 32'd0);
    chk("t4_head",  32'(out_data), 32'h22);
    repeat (3) cyc(0, 0, 0, 0, 1);
    settle();
    chk("t4_last", 32'(out_data), 32'h55);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);

    // 5: asynchronous reset mid-word and mid-burst
    push_word(8'h66, 0, 0);
    push_word(8'h77, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    @(posedge clk);
    #2;
    rst = 1;
    #1;
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_data",  32'(out_data),  32'd0);
    chk("t5_count", 32'(out_count), 32'd0);
    chk("t5_level", 32'(level),     32'd0);
    chk("t5_ovf",   32'(overflow),  32'd0);
    cyc(0, 0, 0, 0, 0);
    rst = 0;
    push_word(8'h5A, 1, 1);
    settle();
    chk("t5_fresh_data",  32'(out_data),  32'h5A);
    chk("t5_fresh_count", 32'(out_count), 32'd4);

    // 6: flush together with the 2nd pair
    cyc(1, 0, 1, 0, 1);
    cyc(1, 1, 0, 1, 1);
    settle();
    chk("t6_data",  32'(out_data),  32'h09);
    chk("t6_count", 32'(out_count), 32'd2);
    cyc(0, 0, 0, 0, 1);

    // 7: mixed traffic with intermittent backpressure and flushes
    for (int i = 0; i < 60; i++) begin
      cyc((i % 3) != 0, i[0], i[1] ^ i[2], (i % 7) == 6, (i % 5) != 1);
    end
    repeat (8) cyc(0, 0, 0, 0, 1);
    settle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
